// File: rtl/shift_ctrl_if.sv
// Request/response handshake bundle for the shift controller.
// The master side issues shift requests and consumes results; the slave side is the controller.
interface shift_ctrl_if #(
    parameter int WIDTH = 32
) ();
    localparam int WSHAM = $clog2(WIDTH);

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_val;
    logic [WSHAM-1:0] req_sham;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_val;

    modport master (
        output req_valid, req_op, req_val, req_sham, resp_ready,
        input  req_ready, resp_valid, resp_val
    );

    modport slave (
        input  req_valid, req_op, req_val, req_sham, resp_ready,
        output req_ready, resp_valid, resp_val
    );
endinterface

// File: rtl/shift_ctrl.sv
// Shift controller: accepts one shift request at a time, sequences an external
// multicycle shift engine (up to 3 bit positions per cycle), and returns the
// result over a valid/ready response channel. Supports flush and a drain state
// that lets an abandoned engine operation run to completion.
module shift_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    shift_ctrl_if.slave              bus,
    output logic [WIDTH-1:0]         eng_val,
    output logic [$clog2(WIDTH)-1:0] eng_sham,
    output logic                     eng_right,
    output logic                     eng_arith,
    output logic                     eng_start,
    input  logic [WIDTH-1:0]         eng_res,
    input  logic                     eng_done
);
    localparam int WSHAM = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WSHAM-1:0] sham_q;
    logic             right_q;
    logic             arith_q;
    logic             accept;

    // A request can only be taken while idle; flush and reset both block it.
    assign bus.req_ready  = (state == IDLE) && !flush && !rst;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_val   = acc;

    // Engine drive: the launch cycle passes the request straight through,
    // every other cycle feeds back the accumulator with the latched operation.
    always_comb begin
        eng_start = accept;
        if (accept) begin
            eng_val   = bus.req_val;
            eng_sham  = bus.req_sham;
            eng_right = bus.req_op[0];
            eng_arith = bus.req_op[0] & bus.req_op[1];
        end else begin
            eng_val   = acc;
            eng_sham  = sham_q;
            eng_right = right_q;
            eng_arith = arith_q;
        end
    end

    // Control FSM with accumulator; DRAIN keeps the engine running but discards its output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            sham_q  <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        right_q <= bus.req_op[0];
                        arith_q <= bus.req_op[0] & bus.req_op[1];
                        sham_q  <= bus.req_sham;
                        acc     <= eng_res;
                        state   <= eng_done ? RESP : SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= eng_res;
                    if (flush) begin
                        state <= eng_done ? IDLE : DRAIN;
                    end else if (eng_done) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (flush || bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (eng_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: a multicycle shift engine model, a latency/result
// reference model checked every cycle, directed scenarios with literal
// expectations, and a randomized phase with flush and backpressure.
module tb_shift_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic [31:0] eng_val, eng_res;
    logic [4:0]  eng_sham;
    logic        eng_right, eng_arith, eng_start, eng_done;

    shift_ctrl_if #(.WIDTH(32)) bus ();

    shift_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .eng_val   (eng_val),
        .eng_sham  (eng_sham),
        .eng_right (eng_right),
        .eng_arith (eng_arith),
        .eng_start (eng_start),
        .eng_res   (eng_res),
        .eng_done  (eng_done)
    );

    always #5 clk = ~clk;

    // ---------------- engine model ----------------
    logic       e_busy;
    logic [4:0] e_rem, e_now, e_amt;

    // Engine datapath: right shifts idle one cycle first, then up to 3 positions per cycle.
    always_comb begin
        e_now = eng_start ? eng_sham : e_rem;
        if (eng_start && eng_right && eng_sham != 5'd0) e_amt = 5'd0;
        else e_amt = (e_now > 5'd3) ? 5'd3 : e_now;
        if (!eng_right) eng_res = eng_val << e_amt;
        else if (eng_arith) eng_res = $unsigned($signed(eng_val) >>> e_amt);
        else eng_res = eng_val >> e_amt;
        eng_done = (eng_start || e_busy) && (e_now == e_amt);
    end

    // Engine progress register, reset by the same rst as the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_busy <= 1'b0;
            e_rem  <= 5'd0;
        end else if (eng_start || e_busy) begin
            e_busy <= !eng_done;
            e_rem  <= e_now - e_amt;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] v, input logic [4:0] k);
        if (!op[0]) return v << k;
        if (op[1]) return $unsigned($signed(v) >>> k);
        return v >> k;
    endfunction

    // Cycle (counted from the launch cycle 0) in which resp_valid first shows.
    function automatic int lat_of(input logic [1:0] op, input logic [4:0] k);
        int kk;
        kk = int'(k);
        if (op[0]) return (kk == 0) ? 1 : (kk + 2) / 3 + 1;
        return (kk <= 1) ? 1 : (kk + 2) / 3;
    endfunction

    // Reference model: t = cycles since launch (-1 when nothing in flight),
    // live = response still owed, exp_v = expected result.
    int          t = -1;
    int          lat = 0;
    bit          live = 1'b0;
    logic [31:0] exp_v = '0;
    int          n_drop = 0;
    int          n_acc = 0;
    int          n_resp = 0;
    bit          chk_en = 1'b0;

    // Per-cycle comparison against the model, then model advance to the next cycle.
    always @(negedge clk) begin
        bit m_idle, m_resp, m_rdy, m_acc;
        if (chk_en) begin
            m_idle = (t < 0);
            m_resp = !m_idle && (t >= lat);
            m_rdy  = m_idle && !flush && !rst;
            m_acc  = bus.req_valid && m_rdy;
            check("req_ready", 32'(bus.req_ready), 32'(m_rdy));
            check("eng_start", 32'(eng_start), 32'(m_acc));
            check("resp_valid", 32'(bus.resp_valid), 32'(m_resp));
            if (m_resp) check("resp_val", bus.resp_val, exp_v);
            if (bus.req_valid && bus.req_ready) n_acc++;
            if (bus.resp_valid && bus.resp_ready && !flush && !rst) n_resp++;
            if (rst) begin
                if (!m_idle && live) n_drop++;
                t = -1;
            end else if (m_idle) begin
                if (m_acc) begin
                    t     = 1;
                    lat   = lat_of(bus.req_op, bus.req_sham);
                    live  = 1'b1;
                    exp_v = ref_shift(bus.req_op, bus.req_val, bus.req_sham);
                end
            end else if (m_resp) begin
                if (flush) begin
                    n_drop++;
                    t = -1;
                end else if (bus.resp_ready) begin
                    t = -1;
                end
            end else begin
                if (flush && live) begin
                    live = 1'b0;
                    n_drop++;
                end
                if (!live && t == lat - 1) t = -1;
                else t++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Launch one request from idle, check latency, value and optional stall behaviour.
    task automatic directed(input string nm, input logic [1:0] op, input logic [31:0] v,
                            input logic [4:0] k, input int exp_lat, input logic [31:0] exp_r,
                            input int stall);
        int  cyc;
        bit  seen;
        bit  extra_start;
        next_cycle();
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_val    = v;
        bus.req_sham   = k;
        bus.resp_ready = (stall == 0);
        @(negedge clk);
        check({nm, "_launch_start"}, 32'(eng_start), 32'd1);
        next_cycle();
        bus.req_valid = 1'b0;
        bus.req_val   = $urandom;
        bus.req_sham  = 5'($urandom);
        cyc = 1;
        seen = 1'b0;
        extra_start = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (eng_start) extra_start = 1'b1;
            if (bus.resp_valid) seen = 1'b1;
            else begin
                cyc++;
                next_cycle();
            end
        end
        check({nm, "_resp_seen"}, 32'(seen), 32'd1);
        check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({nm, "_value"}, bus.resp_val, exp_r);
        check({nm, "_start_once"}, 32'(extra_start), 32'd0);
        for (int i = 1; i < stall; i++) begin
            next_cycle();
            @(negedge clk);
            check({nm, "_stall_valid"}, 32'(bus.resp_valid), 32'd1);
            check({nm, "_stall_val"}, bus.resp_val, exp_r);
            check({nm, "_stall_ready"}, 32'(bus.req_ready), 32'd0);
        end
        if (stall > 0) begin
            next_cycle();
            bus.resp_ready = 1'b1;
            @(negedge clk);
            check({nm, "_hs_valid"}, 32'(bus.resp_valid), 32'd1);
        end
        next_cycle();
        @(negedge clk);
        check({nm, "_idle_valid"}, 32'(bus.resp_valid), 32'd0);
        check({nm, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_val    = '0;
        bus.req_sham   = '0;
        bus.resp_ready = 1'b1;

        // reset
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_val", bus.resp_val, 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_val", bus.resp_val, 32'd0);

        // SLL 1 by 2: done in launch cycle, response in cycle 1
        next_cycle();
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_val = 32'h1; bus.req_sham = 5'd2;
        @(negedge clk);
        check("sll2_done_c0", 32'(eng_done), 32'd1);
        bus.req_valid = 1'b1;
        next_cycle();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("sll2_valid_c1", 32'(bus.resp_valid), 32'd1);
        check("sll2_val_c1", bus.resp_val, 32'h4);
        next_cycle();
        @(negedge clk);
        check("sll2_idle_c2", 32'(bus.req_ready), 32'd1);

        directed("sra7", 2'b11, 32'h8000_0000, 5'd7, 4, 32'hFF00_0000, 0);
        directed("srl31", 2'b01, 32'hF000_0000, 5'd31, 12, 32'h0000_0001, 5);
        directed("op10", 2'b10, 32'h0000_00F0, 5'd4, 2, 32'h0000_0F00, 0);
        directed("sra0", 2'b11, 32'h8000_0001, 5'd0, 1, 32'h8000_0001, 0);

        // flush in SHIFT -> DRAIN, no response, ready after engine completes
        next_cycle();
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_val = 32'h1234_5678; bus.req_sham = 5'd20;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("fl_launch", 32'(eng_start), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            bus.req_valid = 1'b0;
            flush = (c == 2) || (c == 4);
            @(negedge clk);
            check("fl_no_resp", 32'(bus.resp_valid), 32'd0);
            check("fl_ready", 32'(bus.req_ready), 32'(c == 7));
            if (c == 6) check("fl_eng_done", 32'(eng_done), 32'd1);
        end
        flush = 1'b0;
        directed("after_fl", 2'b00, 32'h1, 5'd1, 1, 32'h2, 0);

        // reset in the middle of a long right shift
        next_cycle();
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_val = 32'hDEAD_BEEF; bus.req_sham = 5'd30;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            bus.req_valid = 1'b0;
            rst = (c == 3) || (c == 4);
            @(negedge clk);
            if (c == 4) begin
                check("rst_mid_valid", 32'(bus.resp_valid), 32'd0);
                check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
            end
            if (c == 5) begin
                check("rst_rel_ready", 32'(bus.req_ready), 32'd1);
                check("rst_rel_acc", bus.resp_val, 32'd0);
            end
        end
        directed("after_rst", 2'b11, 32'hFFFF_FFF0, 5'd4, 3, 32'hFFFF_FFFF, 0);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            next_cycle();
            bus.req_valid  = ($urandom_range(0, 2) != 0);
            bus.req_op     = 2'($urandom);
            bus.req_val    = $urandom;
            bus.req_sham   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 15) == 0);
        end
        next_cycle();
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        flush          = 1'b0;
        repeat (20) next_cycle();
        @(negedge clk);
        check("resp_count", 32'(n_resp), 32'(n_acc - n_drop));
        check("final_idle", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
